// File: rtl/melody_rom_if.sv
// Song ROM bus: {song, position} address out, 10-bit note word back
// one clock later.
interface melody_rom_if #(
  parameter int AW = 9
) ();
  logic [AW-1:0] rom_addr;
  logic [9:0]    rom_data;

  modport master (output rom_addr, input rom_data);
  modport slave  (input rom_addr, output rom_data);
endinterface

// File: rtl/melody_sequencer.sv
// Song sequencer: fetches note words from ROM, times each note,
// drives a buzzer note code plus LEDs, with pause/loop/speed/song select.
module melody_sequencer #(
  parameter int unsigned TICKS_PER_UNIT = 10000000,
  parameter int          SONG_W         = 3,
  parameter int          NUM_SONGS      = 6,
  parameter int          ADDR_W         = 6,
  parameter int unsigned GAP_TICKS      = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              play,
  input  logic              song_next,
  input  logic              song_prev,
  input  logic              speed_up,
  input  logic              speed_down,
  input  logic              loop_en,
  melody_rom_if.master      rom,
  output logic [3:0]        note_out,
  output logic [1:0]        octave_out,
  output logic [6:0]        led_out,
  output logic [SONG_W-1:0] song_idx,
  output logic [1:0]        speed_idx,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    IDLE, FETCH, LOAD, PLAY, GAP
  } state_e;

  localparam logic [SONG_W-1:0] LAST_SONG = SONG_W'(NUM_SONGS - 1);
  localparam logic [31:0] TICKS_W = 32'(TICKS_PER_UNIT);
  localparam logic [31:0] GAP_W   = 32'(GAP_TICKS);
  localparam bit          HAS_GAP = (GAP_TICKS != 0);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pos_q, pos_d;
  logic [31:0]         cnt_q, cnt_d;
  logic [SONG_W-1:0]   song_q, song_d;
  logic [1:0]          speed_q, speed_d;
  logic [3:0]          note_q, note_d;
  logic [1:0]          oct_q, oct_d;
  logic [6:0]          led_q, led_d;
  logic [4:0]          in_q, in_d1_q, edge_w;
  logic                armed_q;

  logic                run, play_edge;
  logic                nxt, prv, song_chg, spd_up, spd_dn;
  logic [3:0]          rnote;
  logic [4:0]          dur1, half, eff;
  logic [31:0]         ticks;

  // Play only counts as started once it has been seen low after reset.
  assign edge_w    = in_q & ~in_d1_q;
  assign run       = in_q[0];
  assign play_edge = edge_w[0] & armed_q;
  assign nxt       = edge_w[1] & ~edge_w[2];
  assign prv       = edge_w[2] & ~edge_w[1];
  assign song_chg  = nxt | prv;
  assign spd_up    = edge_w[3] & ~edge_w[4];
  assign spd_dn    = edge_w[4] & ~edge_w[3];

  assign rnote = rom.rom_data[3:0];
  assign dur1  = (rom.rom_data[7:4] == 4'd0) ? 5'd1
                                             : {1'b0, rom.rom_data[7:4]};
  assign half  = dur1 >> 1;

  always_comb begin
    eff = dur1;
    unique case (speed_q)
      2'd0:    eff = dur1 << 1;
      2'd2:    eff = (half == 5'd0) ? 5'd1 : half;
      default: eff = dur1;
    endcase
  end

  assign ticks = 32'(eff) * TICKS_W;

  always_comb begin
    song_d = song_q;
    if (nxt)
      song_d = (song_q == LAST_SONG) ? '0 : song_q + 1'b1;
    else if (prv)
      song_d = (song_q == '0) ? LAST_SONG : song_q - 1'b1;
    speed_d = speed_q;
    if (spd_up && speed_q != 2'd2)
      speed_d = speed_q + 2'd1;
    else if (spd_dn && speed_q != 2'd0)
      speed_d = speed_q - 2'd1;
  end

  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    cnt_d   = cnt_q;
    note_d  = note_q;
    oct_d   = oct_q;
    led_d   = led_q;
    done    = 1'b0;
    if (song_chg && state_q != IDLE) begin
      state_d = FETCH;
      pos_d   = '0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (play_edge) begin
            state_d = FETCH;
            pos_d   = '0;
          end
        end
        FETCH: state_d = LOAD;
        LOAD: begin
          if (rnote == 4'hF) begin
            done    = 1'b1;
            state_d = loop_en ? FETCH : IDLE;
            if (loop_en) pos_d = '0;
          end else begin
            note_d  = rnote;
            oct_d   = rom.rom_data[9:8];
            led_d   = '0;
            if (rnote != 4'd0 && rnote <= 4'd7)
              led_d[rnote[2:0] - 3'd1] = 1'b1;
            cnt_d   = ticks;
            state_d = PLAY;
          end
        end
        PLAY: begin
          if (run) begin
            if (cnt_q <= 32'd1) begin
              if (HAS_GAP) begin
                state_d = GAP;
                cnt_d   = GAP_W;
              end else begin
                state_d = FETCH;
                pos_d   = pos_q + 1'b1;
                cnt_d   = '0;
              end
            end else begin
              cnt_d = cnt_q - 32'd1;
            end
          end
        end
        GAP: begin
          if (run) begin
            if (cnt_q <= 32'd1) begin
              state_d = FETCH;
              pos_d   = pos_q + 1'b1;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q - 32'd1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      pos_q   <= '0;
      cnt_q   <= '0;
      song_q  <= '0;
      speed_q <= 2'd1;
      note_q  <= '0;
      oct_q   <= '0;
      led_q   <= '0;
      in_q    <= '0;
      in_d1_q <= '0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      cnt_q   <= cnt_d;
      song_q  <= song_d;
      speed_q <= speed_d;
      note_q  <= note_d;
      oct_q   <= oct_d;
      led_q   <= led_d;
      in_q    <= {speed_down, speed_up, song_prev, song_next, play};
      in_d1_q <= in_q;
      armed_q <= armed_q | ~play;
    end
  end

  assign rom.rom_addr = {song_q, pos_q};
  assign note_out     = (state_q == PLAY && run) ? note_q : 4'd0;
  assign octave_out   = oct_q;
  assign led_out      = led_q;
  assign song_idx     = song_q;
  assign speed_idx    = speed_q;
  assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_melody_sequencer.sv
// Bench for melody_sequencer: duration/LED vector table, directed corner
// sequences, and random songs checked against a per-cycle trace model.
module tb_melody_sequencer;
  localparam int T   = 4;
  localparam int GAP = 1;
  localparam int SW  = 3;
  localparam int AW  = 6;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic play = 1'b0, loop_en = 1'b0;
  logic song_next = 1'b0, song_prev = 1'b0;
  logic speed_up = 1'b0, speed_down = 1'b0;
  logic [3:0] note_out;
  logic [1:0] octave_out;
  logic [6:0] led_out;
  logic [SW-1:0] song_idx;
  logic [1:0] speed_idx;
  logic busy, done;
  logic [9:0] mem [0:511];

  melody_rom_if #(.AW(SW + AW)) rif ();

  melody_sequencer #(
    .TICKS_PER_UNIT(T), .SONG_W(SW), .NUM_SONGS(6),
    .ADDR_W(AW), .GAP_TICKS(GAP)
  ) dut (
    .clk(clk), .reset(reset), .play(play),
    .song_next(song_next), .song_prev(song_prev),
    .speed_up(speed_up), .speed_down(speed_down),
    .loop_en(loop_en), .rom(rif),
    .note_out(note_out), .octave_out(octave_out), .led_out(led_out),
    .song_idx(song_idx), .speed_idx(speed_idx),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) rif.rom_data <= mem[rif.rom_addr];

  int n_cmp = 0;
  int n_bad = 0;
  logic [9:0] song_q[$];
  int tr[$];

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  function automatic logic [9:0] w(input int n, input int d, input int o);
    return {o[1:0], d[3:0], n[3:0]};
  endfunction

  function automatic int eff_units(input int dur, input int spd);
    int d;
    d = (dur == 0) ? 1 : dur;
    if (spd == 0) return 2 * d;
    if (spd == 2) return (d / 2 < 1) ? 1 : d / 2;
    return d;
  endfunction

  // Expected per-cycle {note, done, busy} from the first FETCH on.
  task automatic build_trace(input int spd);
    int n;
    tr.delete();
    for (int i = 0; i < song_q.size(); i++) begin
      n = int'(song_q[i][3:0]);
      if (n == 15) begin
        tr.push_back(1); tr.push_back(3);
        tr.push_back(0); tr.push_back(0);
        break;
      end
      tr.push_back(1); tr.push_back(1);
      repeat (eff_units(int'(song_q[i][7:4]), spd) * T)
        tr.push_back(n * 4 + 1);
      repeat (GAP) tr.push_back(1);
    end
  endtask

  task automatic write_song(input int s);
    for (int i = 0; i < song_q.size(); i++) mem[s * 64 + i] = song_q[i];
  endtask

  task automatic do_reset(input logic pl);
    reset = 1'b0; play = pl; loop_en = 1'b0;
    {song_next, song_prev, speed_up, speed_down} = 4'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic press(input logic n, input logic p,
                       input logic u, input logic d);
    {song_next, song_prev, speed_up, speed_down} = {n, p, u, d};
    repeat (2) @(negedge clk);
    {song_next, song_prev, speed_up, speed_down} = 4'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic set_speed(input int s);
    if (s == 0) press(0, 0, 0, 1);
    if (s == 2) press(0, 0, 1, 0);
    chk("speed_set", int'(speed_idx), s);
  endtask

  task automatic goto_song(input int s);
    repeat (s) press(1, 0, 0, 0);
    chk("song_sel", int'(song_idx), s);
  endtask

  task automatic wait_note(input int n, output int seen);
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (int'(note_out) == n) begin seen = 1; break; end
    end
  endtask

  task automatic run_song(input string nm, input int spd);
    int lat;
    build_trace(spd);
    play = 1'b1;
    lat = 0;
    for (int j = 1; j <= 10; j++) begin
      @(negedge clk);
      lat = j;
      if (busy) break;
    end
    chk({nm, "_start"}, lat, 2);
    if (!busy) return;
    for (int k = 0; k < tr.size(); k++) begin
      if (k > 0) @(negedge clk);
      chk(nm, int'(note_out) * 4 + int'(done) * 2 + int'(busy), tr[k]);
    end
  endtask

  typedef struct {
    int n; int d; int o; int spd; int len; int led;
  } vec_t;
  vec_t vt[9];

  int idx, got, seen, bad, cnt, dn, wrapped, seen_end;
  int rs, rsp, rlen;

  initial begin
    vt[0] = '{1, 2, 1, 1,   8, 'h01};
    vt[1] = '{7, 3, 2, 0,  24, 'h40};
    vt[2] = '{4, 0, 3, 1,   4, 'h08};
    vt[3] = '{4, 0, 0, 0,   8, 'h08};
    vt[4] = '{5, 0, 1, 2,   4, 'h10};
    vt[5] = '{3, 5, 0, 2,   8, 'h04};
    vt[6] = '{9, 15, 1, 0, 120, 'h00};
    vt[7] = '{0, 1, 2, 1,   4, 'h00};
    vt[8] = '{2, 15, 3, 2, 28, 'h02};
    for (int a = 0; a < 512; a++) mem[a] = 10'h00F;

    repeat (2) @(negedge clk);
    chk("rst_note", int'(note_out), 0);
    chk("rst_oct", int'(octave_out), 0);
    chk("rst_led", int'(led_out), 0);
    chk("rst_song", int'(song_idx), 0);
    chk("rst_speed", int'(speed_idx), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_addr", int'(rif.rom_addr), 0);

    do_reset(1'b1);
    repeat (10) @(negedge clk);
    chk("no_autostart", int'(busy), 0);
    play = 1'b0;
    @(negedge clk);
    song_q = {w(1, 2, 1), w(3, 1, 2), 10'h00F};
    write_song(0);
    run_song("basic", 1);
    chk("basic_led", int'(led_out), 'h04);
    chk("basic_oct", int'(octave_out), 2);

    do_reset(1'b0);
    set_speed(2);
    run_song("fast", 2);

    foreach (vt[v]) begin
      do_reset(1'b0);
      set_speed(vt[v].spd);
      song_q = {w(vt[v].n, vt[v].d, vt[v].o), 10'h00F};
      write_song(0);
      play = 1'b1;
      idx = -1; got = -1;
      for (int c = 0; c < 400; c++) begin
        @(negedge clk);
        if (idx >= 0) idx++;
        else if (busy) idx = 0;
        if (done) begin got = idx - 3 - GAP; break; end
      end
      chk("vec_len", got, vt[v].len);
      chk("vec_led", int'(led_out), vt[v].led);
      chk("vec_oct", int'(octave_out), vt[v].o);
    end

    do_reset(1'b0);
    song_q = {w(1, 2, 1), w(3, 1, 2), 10'h00F};
    write_song(0);
    play = 1'b1;
    wait_note(1, seen);
    chk("pause_start", seen, 1);
    repeat (3) @(negedge clk);
    play = 1'b0;
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (note_out != 4'd0) bad++;
    end
    chk("pause_silent", bad, 0);
    chk("pause_busy", int'(busy), 1);
    play = 1'b1;
    cnt = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (note_out == 4'd1) cnt++;
      else break;
    end
    chk("pause_remain", cnt, 4);

    do_reset(1'b0);
    song_q = {w(1, 2, 1), w(3, 1, 2), 10'h00F};
    write_song(0);
    song_q = {w(5, 3, 0), 10'h00F};
    write_song(1);
    play = 1'b1;
    wait_note(1, seen);
    chk("sn_start", seen, 1);
    song_next = 1'b1;
    @(negedge clk);
    chk("sn_hold", int'(song_idx), 0);
    dn = int'(done);
    @(negedge clk);
    chk("sn_idx", int'(song_idx), 1);
    chk("sn_addr", int'(rif.rom_addr), 64);
    chk("sn_busy", int'(busy), 1);
    song_next = 1'b0;
    @(negedge clk); dn += int'(done);
    @(negedge clk); dn += int'(done);
    chk("sn_nodone", dn, 0);
    chk("sn_note", int'(note_out), 5);

    do_reset(1'b0);
    song_q = {w(1, 2, 1), w(3, 1, 2), 10'h00F};
    write_song(0);
    loop_en = 1'b1;
    play = 1'b1;
    seen = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (done) begin seen = 1; break; end
    end
    chk("loop_done", seen, 1);
    @(negedge clk);
    chk("loop_addr", int'(rif.rom_addr), 0);
    chk("loop_busy", int'(busy), 1);
    repeat (2) @(negedge clk);
    chk("loop_note", int'(note_out), 1);
    seen = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (done) begin seen = 1; break; end
    end
    chk("loop_again", seen, 1);

    do_reset(1'b0);
    press(0, 1, 0, 0);
    chk("prev_wrap", int'(song_idx), 5);
    press(1, 1, 0, 0);
    chk("song_both", int'(song_idx), 5);
    press(1, 0, 0, 0);
    chk("next_wrap", int'(song_idx), 0);
    press(0, 0, 0, 1);
    press(0, 0, 0, 1);
    chk("speed_min", int'(speed_idx), 0);
    press(0, 0, 1, 0);
    press(0, 0, 1, 0);
    press(0, 0, 1, 0);
    chk("speed_max", int'(speed_idx), 2);
    press(0, 0, 1, 1);
    chk("speed_both", int'(speed_idx), 2);

    do_reset(1'b0);
    song_q = {w(1, 2, 1), w(3, 1, 2), 10'h00F};
    write_song(0);
    play = 1'b1;
    wait_note(1, seen);
    chk("rm_start", seen, 1);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("rm_note", int'(note_out), 0);
    chk("rm_busy", int'(busy), 0);
    chk("rm_led", int'(led_out), 0);
    @(negedge clk);

    do_reset(1'b0);
    song_q.delete();
    for (int i = 0; i < 64; i++) song_q.push_back(w(2, 1, 0));
    write_song(3);
    goto_song(3);
    set_speed(2);
    play = 1'b1;
    seen_end = 0; wrapped = 0; dn = 0;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      if (done) dn++;
      if (int'(rif.rom_addr) == 3 * 64 + 63) seen_end = 1;
      else if (seen_end == 1 && int'(rif.rom_addr) == 3 * 64) begin
        wrapped = 1;
        break;
      end
    end
    chk("wrap_seen", wrapped, 1);
    chk("wrap_nodone", dn, 0);
    chk("wrap_busy", int'(busy), 1);

    for (int t = 0; t < 6; t++) begin
      rs   = $urandom_range(5);
      rsp  = $urandom_range(2);
      rlen = $urandom_range(4, 1);
      song_q.delete();
      for (int i = 0; i < rlen; i++)
        song_q.push_back(w($urandom_range(14), $urandom_range(5),
                           $urandom_range(3)));
      song_q.push_back(10'h00F);
      write_song(rs);
      do_reset(1'b0);
      goto_song(rs);
      set_speed(rsp);
      run_song("rand", rsp);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
